// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and subtractor FSM encoding.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [4:0] BCD_RADIX = 5'd10;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow: d = a_d - b_d - bin, corrected mod 10.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  digit_t a_d,
    input  digit_t b_d,
    input  logic   bin,
    output digit_t d,
    output logic   bout,
    output logic   invalid
);

    logic [4:0] w_t;

    // 5-bit two's complement difference; bit 4 set means the digit went negative
    assign w_t     = {1'b0, a_d} - {1'b0, b_d} - {4'b0, bin};
    assign bout    = w_t[4];
    assign d       = bout ? 4'(w_t + BCD_RADIX) : w_t[3:0];
    assign invalid = (a_d > BCD_MAX) | (b_d > BCD_MAX);

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, LSD first, with start/busy/done handshake.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   bout,
    output logic                   err
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned IW = $clog2(NDIGITS) + 1;
    localparam int unsigned SW = (W > 1) ? $clog2(W) : 1;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_diff;
    logic [IW-1:0]   r_idx;
    logic            r_borrow;
    logic            r_busy;
    logic            r_done;
    logic            r_bout;
    logic            r_err;

    logic [SW-1:0]   w_base;
    digit_t          w_a_d;
    digit_t          w_b_d;
    digit_t          w_d;
    logic            w_bout;
    logic            w_invalid;
    logic            w_last;

    assign w_base = SW'({r_idx, 2'b00});
    assign w_a_d  = r_a[w_base +: 4];
    assign w_b_d  = r_b[w_base +: 4];
    assign w_last = (r_idx == IW'(NDIGITS - 1));

    bcd_digit_sub u_digit (
        .a_d     (w_a_d),
        .b_d     (w_b_d),
        .bin     (r_borrow),
        .d       (w_d),
        .bout    (w_bout),
        .invalid (w_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_idx    <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_diff[w_base +: 4] <= w_d;
                    r_borrow            <= w_bout;
                    r_err               <= r_err | w_invalid;
                    r_idx               <= r_idx + IW'(1);
                    if (w_last) begin
                        r_bout  <= w_bout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (4-digit and 1-digit instances).
module tb_bcd_serial_subtractor;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        err;

    logic        start1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        bin1;
    logic        busy1;
    logic        done1;
    logic [3:0]  diff1;
    logic        bout1;
    logic        err1;

    int tests_run;
    int tests_failed;

    bcd_serial_subtractor #(.NDIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .err   (err)
    );

    bcd_serial_subtractor #(.NDIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1),
        .err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op on the 4-digit DUT and wait for done; cycles counts negedges up to done.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          output int cycles);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        cycles = 0;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b err=%b, required all zero",
                     busy, done, diff, bout, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        logic [15:0] held;
        run_op(16'h5678, 16'h1234, 1'b0, cyc);
        tests_run++;
        if (cyc !== 5) begin
            tests_failed++;
            $display("FAIL basic_latency: done seen %0d negedges after start edge, required 5", cyc);
        end
        tests_run++;
        if (diff !== 16'h4444 || bout !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: diff=%h bout=%b err=%b, required 4444/0/0", diff, bout, err);
        end
        held = 16'h4444;
        repeat (3) @(negedge clk);
        tests_run++;
        if (diff !== held || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: diff=%h done=%b busy=%b, required %h/0/0", diff, done, busy, held);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        run_op(16'h1000, 16'h0001, 1'b0, cyc);
        tests_run++;
        if (diff !== 16'h0999 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL ripple: diff=%h bout=%b, required 0999/0", diff, bout);
        end
    endtask

    task automatic test_underflow();
        int cyc;
        run_op(16'h0000, 16'h0001, 1'b0, cyc);
        tests_run++;
        if (diff !== 16'h9999 || bout !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow: diff=%h bout=%b, required 9999/1", diff, bout);
        end
        run_op(16'h0009, 16'h0009, 1'b1, cyc);
        tests_run++;
        if (diff !== 16'h9999 || bout !== 1'b1) begin
            tests_failed++;
            $display("FAIL borrow_in: diff=%h bout=%b, required 9999/1", diff, bout);
        end
    endtask

    task automatic test_err();
        int cyc;
        run_op(16'h00A5, 16'h0001, 1'b0, cyc);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
        run_op(16'h0005, 16'h0001, 1'b0, cyc);
        tests_run++;
        if (diff !== 16'h0004 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: diff=%h err=%b, required 0004/0", diff, err);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic busy_after;
        dones = 0;
        busy_after = 1'b1;
        @(negedge clk);
        a = 16'h5678; b = 16'h1234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                tests_run++;
                if (diff !== 16'h4444) begin
                    tests_failed++;
                    $display("FAIL ignore_result: diff=%h, required 4444", diff);
                end
                @(negedge clk);
                busy_after = busy;
                if (done) dones++;
            end
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL ignore_done_count: done pulses=%0d, required 1", dones);
        end
        tests_run++;
        if (busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_busy_after: busy=%b, required 0", busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        a = 16'h5678; b = 16'h1234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h bout=%b, required 0/0/0000/0",
                     busy, done, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0500, 16'h0250, 1'b0, cyc);
        tests_run++;
        if (diff !== 16'h0250 || bout !== 1'b0 || cyc !== 5) begin
            tests_failed++;
            $display("FAIL after_reset_op: diff=%h bout=%b cyc=%0d, required 0250/0/5", diff, bout, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(16'h4321, 16'h1234, 1'b0, cyc);
        tests_run++;
        if (diff !== 16'h3087 || bout !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: diff=%h bout=%b, required 3087/0", diff, bout);
        end
        run_op(16'h1234, 16'h4321, 1'b1, cyc);
        tests_run++;
        if (diff !== 16'h6912 || bout !== 1'b1 || cyc !== 5) begin
            tests_failed++;
            $display("FAIL b2b_second: diff=%h bout=%b cyc=%0d, required 6912/1/5", diff, bout, cyc);
        end
    endtask

    task automatic test_no_spurious_done();
        int seen;
        seen = 0;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || done1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL spurious_done: done seen %0d times without start, required 0", seen);
        end
    endtask

    task automatic test_sweep_1digit();
        int t;
        int cyc;
        logic [3:0] exp_d;
        logic exp_b;
        for (int ia = 0; ia < 10; ia++) begin
            for (int ib = 0; ib < 10; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    t = ia - ib - ic;
                    exp_b = (t < 0);
                    exp_d = 4'((t < 0) ? t + 10 : t);
                    @(negedge clk);
                    a1 = 4'(ia); b1 = 4'(ib); bin1 = ic[0]; start1 = 1'b1;
                    @(negedge clk);
                    start1 = 1'b0;
                    cyc = 1;
                    while (!done1 && cyc < 10) begin
                        @(negedge clk);
                        cyc++;
                    end
                    tests_run++;
                    if (diff1 !== exp_d || bout1 !== exp_b || err1 !== 1'b0 || cyc !== 2) begin
                        tests_failed++;
                        $display("FAIL sweep_%0d_%0d_%0d: diff=%h bout=%b err=%b cyc=%0d, required %h/%b/0/2",
                                 ia, ib, ic, diff1, bout1, err1, cyc, exp_d, exp_b);
                    end
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start  = 1'b0; a  = '0; b  = '0; bin  = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        test_reset();
        test_no_spurious_done();
        test_basic();
        test_ripple();
        test_underflow();
        test_err();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep_1digit();
        test_no_spurious_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
